seq_shift_add_mul: RTL and testbench
====================================

Name: seq_shift_add_mul

Overview:
- Parametrised, sequential shift-and-add unsigned multiplier; successor to the fixed 4x3 combinational array multiplier.
- Takes operands over a valid/ready input handshake and retires one multiplier bit per clock.
- Returns the full-width product over a valid/ready output handshake.
- Trades latency for area; sits wherever a narrow datapath needs an occasional product without a full array.

Parameters:
- A_W, 4, multiplicand width (bits), >=2
- B_W, 3, multiplier width (bits), >=2; sets the maximum RUN cycle count
- P_W, A_W+B_W, product width; derived, not overridable

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands a/b are valid
- in_ready  output  1  block can accept operands
- a  input  A_W  multiplicand, unsigned
- b  input  B_W  multiplier, unsigned
- out_valid  output  1  product is valid
- out_ready  input  1  consumer accepts product
- product  output  P_W  a*b, unsigned
- busy  output  1  high in RUN or DONE

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset (rst high at an edge):
  - state=IDLE; out_valid=0; product=0; busy=0; internal acc/shift/count registers cleared.
  - in_ready=0 while rst is high.
  - Reset overrides everything, including a mid-RUN operation or a pending DONE. No partial result is ever presented.
- State IDLE:
  - in_ready=1, busy=0, out_valid=0.
  - On an edge with in_valid&in_ready: latch a into mcand, zero-extended to P_W; latch b into mplier shift register; acc=0; idx=0; go to RUN.
- State RUN:
  - in_ready=0, busy=1.
  - Each edge: if mplier[0], acc <= acc + (mcand << idx), computed modulo 2^P_W (never overflows for unsigned operands).
  - Same edge: mplier >>= 1; idx++.
  - Exit to DONE after exactly B_W RUN edges (default build).
- State DONE:
  - out_valid=1; product=acc, held stable until handshake; busy=1; in_ready=0.
  - On edge with out_ready: out_valid=0, go to IDLE.
  - out_valid must not drop without out_ready. product retains its last value after handshake until the next DONE.
- Latency (default build): acceptance at edge T0; out_valid rises after edge T0+B_W. Earliest next acceptance is the edge after the output handshake, so throughput is 1 product per B_W+2 cycles minimum.
- Boundary conditions:
  - in_valid asserted while not IDLE: ignored. The operands must be held by the producer (standard valid/ready).
  - out_ready high before DONE: no effect.
  - a=0 or b=0: product=0, same latency.
  - Max operands: (2^A_W-1)*(2^B_W-1) is exact in P_W bits.
  - Changing a/b after acceptance: no effect on the result.

Optional Feature:
- Macro: SEQ_MUL_EARLY_TERM_EN.
- Defined: RUN exits to DONE at the first edge where the post-shift mplier is zero.
  - Minimum 1 RUN cycle (b=0 gives 1 cycle).
  - Latency = max(1, index of the highest set bit of b, plus 1).
  - Result is identical to the default build.
- Undefined: fixed B_W RUN cycles, as above.

Decomposition:
- Package seq_mul_pkg:
  - state enum type: IDLE=2'd0, RUN=2'd1, DONE=2'd2 (2'd3 is illegal and recovers to IDLE).
  - function for the counter width, clog2(B_W+1).
- One sub-module: add_n, a parametrised P_W ripple-carry adder (sum, cout; cin tied 0). Keeps the adder style consistent with the existing RCA/FA blocks.
- The FSM, shift register and counter stay in the top module.

Test Plan:
- Reset, then a=15, b=7, in_valid pulse, out_ready=1 -> out_valid rises after edge T0+3, product=105 (7'h69), back to IDLE next edge.
- a=9, b=5, out_ready held 0 for 4 cycles -> out_valid and product=45 stable for all 4 cycles; release -> IDLE, in_ready=1.
- rst asserted during the 2nd RUN cycle of a=15, b=7 -> next edge state=IDLE, out_valid=0, product=0; a fresh a=3, b=2 then yields 6.
- in_valid held high continuously with a changing each cycle -> only the values at the acceptance edge are used; in_ready=0 throughout RUN/DONE.
- A_W=8, B_W=8, exhaustive random 500 pairs vs a*b reference -> all match; max case 255*255=65025.
- SEQ_MUL_EARLY_TERM_EN defined:
  - b=1 -> out_valid after T0+1.
  - b=0 -> after T0+1, product=0.
  - b=4 (B_W=3) -> after T0+3.
  - All products correct.

Source files
------------

// File: rtl/seq_mul_pkg.sv
// -----------------------------------------------------------------------------
// seq_mul_pkg
//   Shared types and helpers for the sequential shift-and-add multiplier.
//   - state_e : controller state encoding (2'd3 is unused and recovers to IDLE)
//   - cnt_w() : width of the RUN-cycle index counter for a B_W-bit multiplier
// -----------------------------------------------------------------------------
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The index must be able to hold B_W itself, the value after the last RUN edge.
  function automatic int cnt_w(input int b_w);
    return $clog2(b_w + 1);
  endfunction

endpackage

// File: rtl/seq_shift_add_mul_add_n.sv
// -----------------------------------------------------------------------------
// add_n
//   Parametrised N-bit ripple-carry adder, carry-in fixed at 0, built from
//   full-adder equations so it matches the existing RCA/FA adder style.
// Ports:
//   x_i    [N-1:0]  addend
//   y_i    [N-1:0]  addend
//   sum_o  [N-1:0]  x_i + y_i modulo 2^N
//   cout_o          carry out of the top bit
// -----------------------------------------------------------------------------
module add_n #(
  parameter int N = 7
) (
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] y_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  logic [N:0] carry;

  always_comb begin
    carry    = '0;
    sum_o    = '0;
    carry[0] = 1'b0;
    for (int i = 0; i < N; i++) begin
      sum_o[i]   = x_i[i] ^ y_i[i] ^ carry[i];
      carry[i+1] = (x_i[i] & y_i[i]) | (carry[i] & (x_i[i] ^ y_i[i]));
    end
  end

  assign cout_o = carry[N];

endmodule

// File: rtl/seq_shift_add_mul.sv
// -----------------------------------------------------------------------------
// seq_shift_add_mul
//   Sequential unsigned shift-and-add multiplier. Operands are accepted over a
//   valid/ready handshake, one multiplier bit is retired per clock, and the
//   full-width product is offered over a valid/ready handshake.
//
// Parameters:
//   A_W  multiplicand width (>=2)
//   B_W  multiplier width (>=2), sets the RUN cycle count
//   P_W  product width, A_W+B_W (derived)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands a/b valid
//   in_ready   block can accept operands (IDLE and not in reset)
//   a [A_W]    multiplicand, unsigned
//   b [B_W]    multiplier, unsigned
//   out_valid  product valid (DONE)
//   out_ready  consumer accepts product
//   product    a*b, held until the next result is produced
//   busy       high in RUN or DONE
//
// Build option:
//   SEQ_MUL_EARLY_TERM_EN  when defined, RUN ends on the first edge at which
//                          the shifted multiplier becomes zero (minimum one
//                          RUN cycle). Otherwise RUN always lasts B_W cycles.
// -----------------------------------------------------------------------------
module seq_shift_add_mul
  import seq_mul_pkg::*;
#(
  parameter  int A_W = 4,
  parameter  int B_W = 3,
  localparam int P_W = A_W + B_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] product,
  output logic           busy
);

  localparam int C_W = cnt_w(B_W);
  localparam logic [C_W-1:0] IDX_LAST = C_W'(B_W - 1);

  state_e         state_q, state_d;
  logic [P_W-1:0] mcand_q;
  logic [B_W-1:0] mplier_q;
  logic [P_W-1:0] acc_q;
  logic [C_W-1:0] idx_q;
  logic [P_W-1:0] product_q;

  logic           accept;
  logic           run_last;
  logic [P_W-1:0] addend;
  logic [P_W-1:0] acc_sum;
  logic           add_cout_unused;

  assign accept = in_valid & in_ready;

  // Partial product for this cycle: mcand aligned to the bit being retired.
  assign addend = mplier_q[0] ? (mcand_q << idx_q) : '0;

  add_n #(
    .N (P_W)
  ) u_add (
    .x_i    (acc_q),
    .y_i    (addend),
    .sum_o  (acc_sum),
    .cout_o (add_cout_unused)
  );

`ifdef SEQ_MUL_EARLY_TERM_EN
  // Stop once no set bits remain above the one retired this edge; the index
  // limit still bounds RUN in case the multiplier was all ones.
  assign run_last = (mplier_q[B_W-1:1] == '0) || (idx_q == IDX_LAST);
`else
  assign run_last = (idx_q == IDX_LAST);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept)    state_d = RUN;
      RUN:  if (run_last)  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // Output decode; in_ready is also gated by rst so nothing is accepted
  // while reset is held.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: in_ready = ~rst;
      RUN:  busy     = 1'b1;
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: operand capture, accumulate/shift, result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            mcand_q  <= {{B_W{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            idx_q    <= '0;
          end
        end
        RUN: begin
          acc_q    <= acc_sum;
          mplier_q <= mplier_q >> 1;
          idx_q    <= idx_q + C_W'(1);
          // The product register only changes on the final RUN edge, so it
          // stays stable through DONE and after the handshake.
          if (run_last) begin
            product_q <= acc_sum;
          end
        end
        default: ;
      endcase
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// -----------------------------------------------------------------------------
// tb_seq_shift_add_mul
//   Directed bench for seq_shift_add_mul: a default 4x3 instance for handshake,
//   latency, reset and hold behaviour, plus an 8x8 instance for wide operands.
// -----------------------------------------------------------------------------
module tb_seq_shift_add_mul;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0] a;
  logic [2:0] b;
  logic [6:0] product;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;

  int errors = 0;
  int checks = 0;

  seq_shift_add_mul #(.A_W(4), .B_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  seq_shift_add_mul #(.A_W(8), .B_W(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .product   (product8),
    .busy      (busy8)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Number of RUN edges expected for multiplier value bv of width bw.
  function automatic int exp_lat(input int bv, input int bw);
`ifdef SEQ_MUL_EARLY_TERM_EN
    int l = 1;
    for (int i = 0; i < bw; i++) if (bv[i]) l = i + 1;
    return l;
`else
    return bw;
`endif
  endfunction

  task automatic op4(input logic [3:0] av, input logic [2:0] bv,
                     input int hold, input bit ready_early, input string tag);
    int n;
    a = av; b = bv; in_valid = 1'b1; out_ready = ready_early;
    chk({tag, ".in_ready_idle"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    a = ~av; b = ~bv;   // operands must not matter after acceptance
    chk({tag, ".busy_run"}, busy, 1);
    chk({tag, ".in_ready_run"}, in_ready, 0);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, ".latency"}, n, exp_lat(int'(bv), 3));
    chk({tag, ".product"}, product, int'(av) * int'(bv));
    if (!ready_early) begin
      for (int i = 0; i < hold; i++) begin
        tick();
        chk({tag, ".hold_valid"}, out_valid, 1);
        chk({tag, ".hold_product"}, product, int'(av) * int'(bv));
      end
      out_ready = 1'b1;
    end
    tick();
    out_ready = 1'b0;
    chk({tag, ".valid_after"}, out_valid, 0);
    chk({tag, ".in_ready_after"}, in_ready, 1);
    chk({tag, ".busy_after"}, busy, 0);
    chk({tag, ".product_kept"}, product, int'(av) * int'(bv));
  endtask

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input string tag);
    int n;
    a8 = av; b8 = bv; in_valid8 = 1'b1; out_ready8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, ".product"}, product8, int'(av) * int'(bv));
    tick();
    out_ready8 = 1'b0;
  endtask

  initial begin
    int n;
    logic [7:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;

    // Reset state
    tick();
    tick();
    chk("rst.in_ready", in_ready, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.product", product, 0);
    chk("rst.busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("rst.in_ready_release", in_ready, 1);

    // Directed products, out_ready high early and with held back-pressure
    op4(4'd15, 3'd7, 0, 1'b1, "m15x7");
    op4(4'd9,  3'd5, 4, 1'b0, "m9x5");
    op4(4'd9,  3'd1, 0, 1'b1, "m9x1");
    op4(4'd6,  3'd0, 1, 1'b0, "m6x0");
    op4(4'd0,  3'd5, 0, 1'b1, "m0x5");
    op4(4'd11, 3'd4, 0, 1'b1, "m11x4");

    // Reset during the second RUN cycle discards the operation
    a = 4'd15; b = 3'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("midrst.in_ready", in_ready, 0);
    tick();
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.product", product, 0);
    chk("midrst.busy", busy, 0);
    rst = 1'b0;
    #1;
    op4(4'd3, 3'd2, 0, 1'b1, "m3x2");

    // in_valid held high with a changing every cycle
    a = 4'd5; b = 3'd3; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    n = 0;
    while (!out_valid && n < 40) begin
      chk("stream.in_ready_run", in_ready, 0);
      a = a + 4'd1;
      tick();
      n++;
    end
    chk("stream.latency", n, exp_lat(3, 3));
    chk("stream.in_ready_done", in_ready, 0);
    chk("stream.product", product, 15);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("stream.valid_after", out_valid, 0);
    chk("stream.in_ready_after", in_ready, 1);

    // 8x8 instance: corners then random pairs
    op8(8'd255, 8'd255, "w255x255");
    op8(8'd0,   8'd200, "w0x200");
    op8(8'd128, 8'd2,   "w128x2");
    for (int i = 0; i < 500; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      op8(ra, rb, "wrand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
